word_index_unit: RTL

Registered address-to-word-index translator for the instruction and data memory ports. It replaces the bare combinational `addr >> 2` slice used to index the memory arrays. It subtracts a configurable segment base, checks alignment against the access size, and range-checks against the memory depth. Results pass through one valid/ready pipeline stage, and the block keeps sticky error status and a saturating error counter for the exception logic.

---
 rtl/word_index_unit_pkg.sv | 16 +
 rtl/word_index_unit_if.sv | 27 ++
 rtl/word_index_unit_addr_check.sv | 40 ++++
 rtl/word_index_unit.sv | 89 ++++++++
 4 files changed

// File: rtl/word_index_unit_pkg.sv
// Shared encodings for the word index unit: access sizes, error bit
// positions and error counter width.
package wiu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } size_e;

   localparam int ERR_MIS   = 0;
   localparam int ERR_RNG   = 1;
   localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/word_index_unit_if.sv
// Request/result handshake bundle between a memory port and the word
// index unit. master drives requests and accepts results; slave is the unit.
interface word_index_unit_if #(
   parameter int ADDR_W = 32,
   parameter int IDX_W  = 12
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr;
   logic [1:0]        in_size;
   logic              out_valid;
   logic              out_ready;
   logic [IDX_W-1:0]  out_idx;
   logic [1:0]        out_boff;
   logic              out_misalign;
   logic              out_range;

   modport master (
      output in_valid, in_addr, in_size, out_ready,
      input  in_ready, out_valid, out_idx, out_boff, out_misalign, out_range
   );

   modport slave (
      input  in_valid, in_addr, in_size, out_ready,
      output in_ready, out_valid, out_idx, out_boff, out_misalign, out_range
   );
endinterface

// File: rtl/word_index_unit_addr_check.sv
// Combinational address translation: segment-relative word index plus
// alignment and range checks. The index is zeroed whenever a flag is set.
module addr_check
   import wiu_pkg::*;
#(
   parameter int                ADDR_W = 32,
   parameter int                IDX_W  = 12,
   parameter logic [ADDR_W-1:0] BASE   = 'h3000,
   parameter int                DEPTH  = 4096
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        size,
   output logic [IDX_W-1:0]  idx,
   output logic              mis,
   output logic              rng
);
   localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] word;

   // Offset wraps modulo 2^ADDR_W; addresses below BASE are caught by the
   // explicit compare rather than by the wrapped word value.
   assign offset = addr - BASE;
   assign word   = offset >> 2;
   assign rng    = (addr < BASE) || (word >= DEPTH_W);

   // Alignment requirement depends on access size; reserved size always faults.
   always_comb begin
      mis = 1'b0;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = addr[0];
         SZ_WORD: mis = |addr[1:0];
         default: mis = 1'b1;
      endcase
   end

   assign idx = (mis || rng) ? '0 : word[IDX_W-1:0];
endmodule

// File: rtl/word_index_unit.sv
// Registered address-to-word-index translator. One valid/ready output
// stage, sticky error status and a saturating error counter.
module word_index_unit
   import wiu_pkg::*;
#(
   parameter int                ADDR_W = 32,
   parameter int                IDX_W  = 12,
   parameter logic [ADDR_W-1:0] BASE   = 'h3000,
   parameter int                DEPTH  = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   word_index_unit_if.slave     bus,
   input  logic                 err_clr,
   output logic [1:0]           err_sticky,
   output logic [ERR_CNT_W-1:0] err_cnt
);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   logic             c_mis, c_rng, acc, c_err;
   logic [IDX_W-1:0] c_idx;
   logic             vld_q, mis_q, rng_q;
   logic [IDX_W-1:0] idx_q;
   logic [1:0]       boff_q;
   logic [1:0]       c_flags;

   addr_check #(
      .ADDR_W (ADDR_W),
      .IDX_W  (IDX_W),
      .BASE   (BASE),
      .DEPTH  (DEPTH)
   ) u_chk (
      .addr (bus.in_addr),
      .size (bus.in_size),
      .idx  (c_idx),
      .mis  (c_mis),
      .rng  (c_rng)
   );

   assign bus.in_ready = !vld_q || bus.out_ready;
   assign acc          = bus.in_valid && bus.in_ready;
   assign c_err        = c_mis || c_rng;

   always_comb begin
      c_flags          = '0;
      c_flags[ERR_MIS] = c_mis;
      c_flags[ERR_RNG] = c_rng;
   end

   // Output stage: load on accept, drop valid once consumed with nothing new.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q  <= 1'b0;
         idx_q  <= '0;
         boff_q <= '0;
         mis_q  <= 1'b0;
         rng_q  <= 1'b0;
      end else if (acc) begin
         vld_q  <= 1'b1;
         idx_q  <= c_idx;
         boff_q <= bus.in_addr[1:0];
         mis_q  <= c_mis;
         rng_q  <= c_rng;
      end else if (bus.out_ready) begin
         vld_q  <= 1'b0;
      end
   end

   // Error status updates at accept time; a new error outranks a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_sticky <= '0;
         err_cnt    <= '0;
      end else if (acc && c_err) begin
         err_sticky <= (err_clr ? 2'b00 : err_sticky) | c_flags;
         if (err_clr)               err_cnt <= ERR_CNT_W'(1);
         else if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
      end else if (err_clr) begin
         err_sticky <= '0;
         err_cnt    <= '0;
      end
   end

   assign bus.out_valid    = vld_q;
   assign bus.out_idx      = idx_q;
   assign bus.out_boff     = boff_q;
   assign bus.out_misalign = mis_q;
   assign bus.out_range    = rng_q;
endmodule
